// File: rtl/mandel_pkg.sv
// Shared definitions for the Mandelbrot pixel scheduler.
//   state_e   : scheduler FSM states
//   FRAC_BITS : fractional bits of the Q16.16 coordinate format
//   ONE       : 1.0 in Q16.16
package mandel_pkg;
  localparam int          FRAC_BITS = 16;
  localparam logic [31:0] ONE       = 32'h0001_0000;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    ARM    = 3'd2,
    WAIT   = 3'd3,
    EMIT   = 3'd4
  } state_e;
endpackage

// File: rtl/mandel_raster_ctr.sv
// Raster position generator: steps (col,row) across the frame and keeps the
// matching complex-plane coordinate (x,y) in Q16.16.
// Ports:
//   clk_i, rst_ni          : clock, synchronous active-low reset
//   init_i                 : load start of frame (col=row=0, x/y from init_*)
//   adv_i                  : advance to the next pixel
//   init_x_i, init_y_i     : top-left coordinate taken on init_i
//   x_min_i, step_i        : latched left edge and pixel pitch
//   width_i, height_i      : latched frame size
//   col_o, row_o, x_o, y_o : current pixel position / coordinate
//   last_o                 : current pixel is the final pixel of the frame
module mandel_raster_ctr
  import mandel_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int COORD_WIDTH = 11
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   init_i,
  input  logic                   adv_i,
  input  logic [DATA_WIDTH-1:0]  init_x_i,
  input  logic [DATA_WIDTH-1:0]  init_y_i,
  input  logic [DATA_WIDTH-1:0]  x_min_i,
  input  logic [DATA_WIDTH-1:0]  step_i,
  input  logic [COORD_WIDTH-1:0] width_i,
  input  logic [COORD_WIDTH-1:0] height_i,
  output logic [COORD_WIDTH-1:0] col_o,
  output logic [COORD_WIDTH-1:0] row_o,
  output logic [DATA_WIDTH-1:0]  x_o,
  output logic [DATA_WIDTH-1:0]  y_o,
  output logic                   last_o
);
  localparam logic [COORD_WIDTH-1:0] COORD_ONE = COORD_WIDTH'(1);

  logic [COORD_WIDTH-1:0] col_q, col_d, row_q, row_d;
  logic [DATA_WIDTH-1:0]  x_q, x_d, y_q, y_d;
  logic                   col_end, row_end;

  assign col_end = (col_q == width_i - COORD_ONE);
  assign row_end = (row_q == height_i - COORD_ONE);

  // Coordinates wrap modulo 2^DATA_WIDTH; y decreases going down the frame.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    x_d   = x_q;
    y_d   = y_q;
    if (init_i) begin
      col_d = '0;
      row_d = '0;
      x_d   = init_x_i;
      y_d   = init_y_i;
    end else if (adv_i) begin
      if (col_end) begin
        col_d = '0;
        x_d   = x_min_i;
        row_d = row_q + COORD_ONE;
        y_d   = y_q - step_i;
      end else begin
        col_d = col_q + COORD_ONE;
        x_d   = x_q + step_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      col_q <= '0;
      row_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      x_q   <= x_d;
      y_q   <= y_d;
    end
  end

  assign col_o  = col_q;
  assign row_o  = row_q;
  assign x_o    = x_q;
  assign y_o    = y_q;
  assign last_o = col_end & row_end;
endmodule

// File: rtl/mandel_pixel_sched.sv
// Mandelbrot pixel scheduler: walks a frame pixel by pixel, launches the
// iteration core for each pixel's c, and streams (col,row,iter,last) results
// out on a valid/ready interface.
// Ports:
//   clk_i, rst_ni                   : clock, synchronous active-low reset
//   frame_start_i + config inputs   : x_min/y_max/step (Q16.16), width/height,
//                                     max_iter; sampled only when accepted
//   core_start_o, core_x0_o/y0_o,
//   core_max_iter_o                 : launch and operands for the core
//   core_iter_i, core_done_i        : core result (done is a level)
//   pix_valid_o/ready_i, pix_*      : result stream
//   busy_o                          : frame in progress
//   perf_cycles_o                   : busy-cycle counter
// Optional feature: define MANDEL_SCHED_PERF_EN to build the saturating
// busy-cycle counter; otherwise perf_cycles_o is tied to 0.
module mandel_pixel_sched
  import mandel_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int MAX_ITER_WIDTH = 16,
  parameter int COORD_WIDTH    = 11
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      frame_start_i,
  input  logic [DATA_WIDTH-1:0]     x_min_i,
  input  logic [DATA_WIDTH-1:0]     y_max_i,
  input  logic [DATA_WIDTH-1:0]     step_i,
  input  logic [COORD_WIDTH-1:0]    width_i,
  input  logic [COORD_WIDTH-1:0]    height_i,
  input  logic [MAX_ITER_WIDTH-1:0] max_iter_i,
  output logic                      core_start_o,
  output logic [DATA_WIDTH-1:0]     core_x0_o,
  output logic [DATA_WIDTH-1:0]     core_y0_o,
  output logic [MAX_ITER_WIDTH-1:0] core_max_iter_o,
  input  logic [MAX_ITER_WIDTH-1:0] core_iter_i,
  input  logic                      core_done_i,
  output logic                      pix_valid_o,
  input  logic                      pix_ready_i,
  output logic [COORD_WIDTH-1:0]    pix_col_o,
  output logic [COORD_WIDTH-1:0]    pix_row_o,
  output logic [MAX_ITER_WIDTH-1:0] pix_iter_o,
  output logic                      pix_last_o,
  output logic                      busy_o,
  output logic [31:0]               perf_cycles_o
);
  state_e                    state_q, state_d;
  logic [DATA_WIDTH-1:0]     x_min_q, x_min_d, step_q, step_d;
  logic [COORD_WIDTH-1:0]    width_q, width_d, height_q, height_d;
  logic [MAX_ITER_WIDTH-1:0] max_iter_q, max_iter_d, iter_q, iter_d;
  logic                      accept, adv, last;

  assign accept = (state_q == IDLE) && frame_start_i &&
                  (width_i != '0) && (height_i != '0);
  assign adv    = (state_q == EMIT) && pix_ready_i && !last;

  always_comb begin
    state_d    = state_q;
    x_min_d    = x_min_q;
    step_d     = step_q;
    width_d    = width_q;
    height_d   = height_q;
    max_iter_d = max_iter_q;
    iter_d     = iter_q;
    case (state_q)
      IDLE: if (accept) begin
        x_min_d    = x_min_i;
        step_d     = step_i;
        width_d    = width_i;
        height_d   = height_i;
        max_iter_d = max_iter_i;
        state_d    = LAUNCH;
      end
      LAUNCH: state_d = ARM;
      // core_done_i may still be high from the previous pixel; skip it.
      ARM:    state_d = WAIT;
      WAIT: if (core_done_i) begin
        iter_d  = core_iter_i;
        state_d = EMIT;
      end
      EMIT: if (pix_ready_i) state_d = last ? IDLE : LAUNCH;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      x_min_q    <= '0;
      step_q     <= '0;
      width_q    <= '0;
      height_q   <= '0;
      max_iter_q <= '0;
      iter_q     <= '0;
    end else begin
      state_q    <= state_d;
      x_min_q    <= x_min_d;
      step_q     <= step_d;
      width_q    <= width_d;
      height_q   <= height_d;
      max_iter_q <= max_iter_d;
      iter_q     <= iter_d;
    end
  end

  // x/y only move on an EMIT handshake, so c is stable from LAUNCH to WAIT exit.
  mandel_raster_ctr #(
    .DATA_WIDTH (DATA_WIDTH),
    .COORD_WIDTH(COORD_WIDTH)
  ) u_raster (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .init_i  (accept),
    .adv_i   (adv),
    .init_x_i(x_min_i),
    .init_y_i(y_max_i),
    .x_min_i (x_min_q),
    .step_i  (step_q),
    .width_i (width_q),
    .height_i(height_q),
    .col_o   (pix_col_o),
    .row_o   (pix_row_o),
    .x_o     (core_x0_o),
    .y_o     (core_y0_o),
    .last_o  (last)
  );

  assign core_start_o    = (state_q == LAUNCH);
  assign core_max_iter_o = max_iter_q;
  assign pix_valid_o     = (state_q == EMIT);
  assign pix_iter_o      = iter_q;
  assign pix_last_o      = last;
  assign busy_o          = (state_q != IDLE);

`ifdef MANDEL_SCHED_PERF_EN
  logic [31:0] perf_q, perf_d;

  // Accept happens in IDLE, so clear and count never coincide.
  always_comb begin
    perf_d = perf_q;
    if (accept)                          perf_d = '0;
    else if (busy_o && (perf_q != '1))   perf_d = perf_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) perf_q <= '0;
    else         perf_q <= perf_d;
  end

  assign perf_cycles_o = perf_q;
`else
  assign perf_cycles_o = 32'd0;
`endif
endmodule
